// File: rtl/fir_mc_pkg.sv
// Shared definitions for the multi-channel FIR: controller states and default sizing.
package fir_mc_pkg;

    localparam int DEF_INWIDTH     = 16;
    localparam int DEF_COEFWIDTH   = 16;
    localparam int DEF_OUTWIDTH    = 38;
    localparam int DEF_COEFNUM     = 64;
    localparam int DEF_LOGCOEFNUM  = 6;
    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_LOGCHANNELS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

endpackage

// File: rtl/fir_mc_hist.sv
// Per-channel circular sample history with its own write pointer; reads are tap-indexed
// relative to the newest sample of the selected channel.
module fir_mc_hist
    import fir_mc_pkg::*;
#(
    parameter int INWIDTH     = DEF_INWIDTH,
    parameter int COEFNUM     = DEF_COEFNUM,
    parameter int LOGCOEFNUM  = DEF_LOGCOEFNUM,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int LOGCHANNELS = DEF_LOGCHANNELS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [LOGCHANNELS-1:0] wr_chan,
    input  logic [INWIDTH-1:0]     wr_data,
    input  logic [LOGCHANNELS-1:0] rd_chan,
    input  logic [LOGCOEFNUM-1:0]  rd_tap,
    output logic [INWIDTH-1:0]     rd_data
);

    logic [INWIDTH-1:0]    mem    [CHANNELS][COEFNUM];
    logic [LOGCOEFNUM-1:0] wr_ptr [CHANNELS];
    logic [LOGCOEFNUM-1:0] rd_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                for (int k = 0; k < COEFNUM; k++) begin
                    mem[c][k] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[wr_chan][wr_ptr[wr_chan]] <= wr_data;
            wr_ptr[wr_chan]               <= wr_ptr[wr_chan] + 1'b1;
        end
    end

    // The pointer already sits one past the newest sample, so tap k is k+1 slots back.
    assign rd_idx  = wr_ptr[rd_chan] - rd_tap - 1'b1;
    assign rd_data = mem[rd_chan][rd_idx];

endmodule

// File: rtl/fir_mc.sv
// Multi-channel FIR filter: one shared coefficient set, time-multiplexed single MAC,
// one result per accepted sample.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a sample; coefficient writes accepted
// ST_MAC  | one tap product accumulated per cycle, COEFNUM cycles
// ST_DONE | result and channel registered, output_valid pulses next
module fir_mc
    import fir_mc_pkg::*;
#(
    parameter int INWIDTH     = DEF_INWIDTH,
    parameter int COEFWIDTH   = DEF_COEFWIDTH,
    parameter int OUTWIDTH    = DEF_OUTWIDTH,
    parameter int COEFNUM     = DEF_COEFNUM,
    parameter int LOGCOEFNUM  = DEF_LOGCOEFNUM,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int LOGCHANNELS = DEF_LOGCHANNELS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [LOGCHANNELS-1:0] input_channel,
    input  logic [INWIDTH-1:0]     FIR_input,
    input  logic                   coef_we,
    input  logic [LOGCOEFNUM-1:0]  coef_addr,
    input  logic [COEFWIDTH-1:0]   coef_data,
    output logic                   coef_err,
    output logic                   output_valid,
    output logic [LOGCHANNELS-1:0] output_channel,
    output logic [OUTWIDTH-1:0]    FIR_output
);

    localparam int PRODW = INWIDTH + COEFWIDTH;

    fir_state_e state, state_nxt;

    logic                         accept;
    logic                         coef_wr;
    logic                         tap_carry;
    logic [LOGCOEFNUM-1:0]        tap_cnt;
    logic [LOGCOEFNUM-1:0]        tap_inc;
    logic [LOGCHANNELS-1:0]       act_chan;
    logic [INWIDTH-1:0]           hist_data;
    logic signed [COEFWIDTH-1:0]  coef_mem [COEFNUM];
    logic signed [PRODW-1:0]      product;
    logic signed [OUTWIDTH-1:0]   acc;
    logic signed [OUTWIDTH-1:0]   acc_sum;

    fir_mc_hist #(
        .INWIDTH     (INWIDTH),
        .COEFNUM     (COEFNUM),
        .LOGCOEFNUM  (LOGCOEFNUM),
        .CHANNELS    (CHANNELS),
        .LOGCHANNELS (LOGCHANNELS)
    ) u_hist (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept),
        .wr_chan (input_channel),
        .wr_data (FIR_input),
        .rd_chan (act_chan),
        .rd_tap  (tap_cnt),
        .rd_data (hist_data)
    );

    // Carry out of the tap counter marks the last product of the sweep.
    assign {tap_carry, tap_inc} = {1'b0, tap_cnt} + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        input_ready = 1'b0;
        accept      = 1'b0;
        coef_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                input_ready = 1'b1;
                coef_wr     = coef_we;
                if (input_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (tap_carry) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Exact signed product, sign-extended into the wide accumulator.
    assign product = $signed(hist_data) * coef_mem[tap_cnt];
    assign acc_sum = acc + {{(OUTWIDTH - PRODW){product[PRODW-1]}}, product};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < COEFNUM; k++) begin
                coef_mem[k] <= '0;
            end
        end else if (coef_wr) begin
            coef_mem[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc            <= '0;
            tap_cnt        <= '0;
            act_chan       <= '0;
            coef_err       <= 1'b0;
            output_valid   <= 1'b0;
            output_channel <= '0;
            FIR_output     <= '0;
        end else begin
            coef_err     <= coef_we && (state != ST_IDLE);
            output_valid <= (state == ST_DONE);
            if (accept) begin
                acc      <= '0;
                tap_cnt  <= '0;
                act_chan <= input_channel;
            end else if (state == ST_MAC) begin
                acc     <= acc_sum;
                tap_cnt <= tap_inc;
            end
            if (state == ST_DONE) begin
                FIR_output     <= acc;
                output_channel <= act_chan;
            end
        end
    end

endmodule

// File: tb/tb_fir_mc.sv
// Randomized self-checking bench for fir_mc (4 taps, 2 channels) against a queue-based
// convolution model.
module tb_fir_mc;

    localparam int INW = 16;
    localparam int CW  = 16;
    localparam int OW  = 38;
    localparam int N   = 4;
    localparam int LN  = 2;
    localparam int NCH = 2;
    localparam int LCH = 1;

    logic           clock = 1'b0;
    logic           reset;
    logic           input_valid;
    logic           input_ready;
    logic [LCH-1:0] input_channel;
    logic [INW-1:0] FIR_input;
    logic           coef_we;
    logic [LN-1:0]  coef_addr;
    logic [CW-1:0]  coef_data;
    logic           coef_err;
    logic           output_valid;
    logic [LCH-1:0] output_channel;
    logic [OW-1:0]  FIR_output;

    int     n_vec = 0;
    int     n_err = 0;
    longint hm [N];
    int     hq [NCH][$];
    longint last_y;

    fir_mc #(
        .INWIDTH(INW), .COEFWIDTH(CW), .OUTWIDTH(OW), .COEFNUM(N),
        .LOGCOEFNUM(LN), .CHANNELS(NCH), .LOGCHANNELS(LCH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .input_channel  (input_channel),
        .FIR_input      (FIR_input),
        .coef_we        (coef_we),
        .coef_addr      (coef_addr),
        .coef_data      (coef_data),
        .coef_err       (coef_err),
        .output_valid   (output_valid),
        .output_channel (output_channel),
        .FIR_output     (FIR_output)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // y[n] = sum_k h[k] * x[n-k], newest sample at the queue front, zeros before history.
    function automatic longint model_push(input int ch, input int x);
        longint y = 0;
        hq[ch].push_front(x);
        for (int k = 0; k < N; k++) begin
            if (k < hq[ch].size()) y += hm[k] * longint'(hq[ch][k]);
        end
        return y;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NCH; c++) hq[c].delete();
        for (int k = 0; k < N; k++) hm[k] = 0;
    endfunction

    task automatic coef_write(input int k, input int d);
        @(negedge clock);
        coef_we   = 1'b1;
        coef_addr = k[LN-1:0];
        coef_data = d[CW-1:0];
        @(posedge clock);
        #1 coef_we = 1'b0;
        hm[k] = d;
        chk("coef_err_idle", coef_err, 0);
    endtask

    task automatic load_h(input int h0, input int h1, input int h2, input int h3);
        coef_write(0, h0);
        coef_write(1, h1);
        coef_write(2, h2);
        coef_write(3, h3);
    endtask

    task automatic send(input int ch, input int x, input bit mac_wr);
        int wait_n = 0;
        int lat = 0;
        longint y;
        @(negedge clock);
        input_valid   = 1'b1;
        input_channel = ch[LCH-1:0];
        FIR_input     = x[INW-1:0];
        while (!input_ready && wait_n < 20) begin
            @(negedge clock);
            wait_n++;
        end
        if (!input_ready) chk("ready_timeout", input_ready, 1);
        @(posedge clock);
        #1 input_valid = 1'b0;
        y = model_push(ch, x);
        if (mac_wr) begin
            @(negedge clock);
            coef_we   = 1'b1;
            coef_addr = '0;
            coef_data = 16'd9;
            @(posedge clock);
            #1 coef_we = 1'b0;
            lat = 1;
            chk("coef_err_pulse", coef_err, 1);
        end
        do begin
            @(posedge clock);
            #1 lat++;
        end while (!output_valid && lat < 20);
        chk("latency", lat, N + 1);
        chk("fir_output", $signed(FIR_output), y);
        chk("output_channel", output_channel, ch);
        if (mac_wr) chk("coef_err_clear", coef_err, 0);
        last_y = y;
        @(posedge clock);
        #1 chk("ov_one_cycle", output_valid, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, input_ready, 1);
        chk({tag, "_ov"}, output_valid, 0);
        chk({tag, "_err"}, coef_err, 0);
        chk({tag, "_och"}, output_channel, 0);
        chk({tag, "_out"}, $signed(FIR_output), 0);
    endtask

    initial begin
        longint exp_y[$];
        int     exp_c[$];
        int     acc_cyc[$];
        int     ov_seen;
        int     x;
        int     ch;

        reset = 1'b0;
        input_valid = 1'b0;
        input_channel = '0;
        FIR_input = '0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_clear();
        #2 check_idle_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        // impulse response
        load_h(1, 2, 3, 4);
        send(0, 1, 0);
        chk("impulse_y0", last_y, 1);
        for (int i = 0; i < 4; i++) send(0, 0, 0);

        // channel isolation
        send(0, 1, 0);
        send(1, 5, 0);
        send(1, 0, 0);
        send(0, 0, 0);
        chk("isolation_ch0", last_y, 2);

        // extremes
        load_h(-32768, -32768, -32768, -32768);
        for (int i = 0; i < 5; i++) send(0, -32768, 0);
        chk("extreme_steady", $signed(FIR_output), 64'sd4294967296);

        // coefficient write dropped during MAC
        load_h(1, 2, 3, 4);
        for (int i = 0; i < 4; i++) send(0, 0, 0);
        send(0, 1, 1);
        send(0, 0, 0);
        chk("dropped_wr_h1", last_y, 2);

        // reset in the middle of MAC
        @(negedge clock);
        input_valid = 1'b1;
        input_channel = '0;
        FIR_input = 16'd1;
        @(posedge clock);
        #1 input_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 check_idle_outputs("mid_mac_reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        ov_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1 if (output_valid) ov_seen++;
        end
        chk("aborted_no_ov", ov_seen, 0);
        send(0, 1, 0);
        chk("coef_zero_after_reset", last_y, 0);
        load_h(1, 2, 3, 4);
        send(1, 1, 0);
        chk("post_reset_impulse", last_y, 1);

        // randomized traffic with occasional idle coefficient updates
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0)
                coef_write($urandom_range(0, N - 1), int'($urandom_range(0, 65535)) - 32768);
            send($urandom_range(0, NCH - 1), int'($urandom_range(0, 65535)) - 32768, 0);
        end

        // backpressure: valid held high continuously
        input_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clock);
            if (input_ready) begin
                x  = int'($urandom_range(0, 65535)) - 32768;
                ch = $urandom_range(0, NCH - 1);
                FIR_input = x[INW-1:0];
                input_channel = ch[LCH-1:0];
                exp_y.push_back(model_push(ch, x));
                exp_c.push_back(ch);
                acc_cyc.push_back(cyc);
            end
            @(posedge clock);
            #1 if (output_valid) begin
                if (exp_y.size() == 0) chk("bp_spurious_ov", 1, 0);
                else begin
                    chk("bp_y", $signed(FIR_output), exp_y.pop_front());
                    chk("bp_ch", output_channel, exp_c.pop_front());
                end
            end
        end
        @(negedge clock);
        input_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1 if (output_valid && exp_y.size() > 0) begin
                chk("bp_y", $signed(FIR_output), exp_y.pop_front());
                chk("bp_ch", output_channel, exp_c.pop_front());
            end
        end
        chk("bp_drained", exp_y.size(), 0);
        chk("bp_accept_count", acc_cyc.size() >= 6, 1);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("bp_accept_gap", acc_cyc[i] - acc_cyc[i-1], N + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_mc.md
FIR_MC -- requirements
Module: fir_mc

Interface
REQ-001 Parameter INWIDTH, default 16, sample width, signed two's complement.
REQ-002 Parameter COEFWIDTH, default 16, coefficient width, signed.
REQ-003 Parameter OUTWIDTH, default 38, output width, signed; SHALL be >= INWIDTH+COEFWIDTH+LOGCOEFNUM.
REQ-004 Parameter COEFNUM, default 64, taps, power of two; LOGCOEFNUM, default 6, its log2.
REQ-005 Parameter CHANNELS, default 4, independent channels, power of two; LOGCHANNELS, default 2, its log2.
REQ-006 clock  in  1  single clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 input_valid  in  1  sample offered.
REQ-009 input_ready  out  1  block can accept a sample.
REQ-010 input_channel  in  LOGCHANNELS  channel of offered sample.
REQ-011 FIR_input  in  INWIDTH  sample value.
REQ-012 coef_we  in  1  coefficient write strobe.
REQ-013 coef_addr  in  LOGCOEFNUM  tap index k.
REQ-014 coef_data  in  COEFWIDTH  value of h[k], shared by all channels.
REQ-015 coef_err  out  1  one-cycle pulse: write dropped because busy.
REQ-016 output_valid  out  1  one-cycle pulse: result present.
REQ-017 output_channel  out  LOGCHANNELS  channel of result.
REQ-018 FIR_output  out  OUTWIDTH  result, held until next result.

Function
REQ-019 Per channel c: y[n] = sum over k=0..COEFNUM-1 of h[k]*x_c[n-k], exact, sign-extended, no rounding or saturation.
REQ-020 States IDLE, MAC, DONE; input_ready SHALL be 1 only in IDLE.
REQ-021 Sample accepted when input_valid and input_ready high on an edge; it is written at channel c's circular write pointer, pointer advances modulo COEFNUM, accumulator clears, tap counter=0, IDLE->MAC.
REQ-022 MAC: one product per cycle, tap k paired with x_c[n-k]; after COEFNUM cycles (counter carry-out) MAC->DONE.
REQ-023 DONE: FIR_output and output_channel register, output_valid pulses one cycle, DONE->IDLE.
REQ-024 Latency: output_valid SHALL assert exactly COEFNUM+1 cycles after the accepting edge; throughput one sample per COEFNUM+2 cycles.
REQ-025 History of other channels SHALL be untouched by a channel's activity.
REQ-026 coef_we in IDLE writes h[coef_addr] on that edge; a sample accepted on the same edge uses the new value.
REQ-027 coef_we in MAC or DONE SHALL be dropped, coefficient memory unchanged, coef_err pulses next cycle.
REQ-028 input_valid while not ready: sample not accepted, no state change; source holds data.
REQ-029 Pointer wrap: after COEFNUM samples on a channel, oldest sample overwritten; no flag.

Reset
REQ-030 On reset low, asynchronously: state IDLE, input_ready 1, output_valid 0, coef_err 0, output_channel 0, FIR_output 0, all write pointers 0, accumulator 0.
REQ-031 History memory and coefficients SHALL read as zero after reset (cleared via flag vector or sequential clear; if a clear sequence is used, input_ready stays 0 until done, max COEFNUM cycles).
REQ-032 Reset mid-MAC aborts the computation; no output_valid produced for it.

Structure
REQ-033 Package fir_mc_pkg holds the state enumeration and default parameter constants.
REQ-034 One sub-module fir_mc_hist: per-channel circular history storage with write pointers and tap-indexed read.

Verification (bench: COEFNUM=4, CHANNELS=2, h={1,2,3,4})
REQ-035 Impulse: ch0 samples 1,0,0,0,0 -> outputs 1,2,3,4,0, each COEFNUM+1=5 cycles after acceptance, output_channel 0.
REQ-036 Isolation: ch0 sample 1, then ch1 samples 5,0 -> ch1 outputs 5,10; then ch0 sample 0 -> output 2.
REQ-037 Extremes: ch0 -32768 x5 with h all -32768 -> steady output 4*2^30=4294967296, no overflow.
REQ-038 Coef write during MAC to h[0]=9 -> coef_err pulse, next impulse output still 1.
REQ-039 Reset asserted at MAC cycle 2 -> no output_valid, all outputs 0, next impulse yields 1.
REQ-040 Backpressure: input_valid held high continuously -> input_ready low during MAC/DONE, one acceptance per 6 cycles.
